// File: rtl/arbiter8way16.sv
// Round-robin arbiter sharing one 16-bit datapath among eight requesters, with a hold limit.
// Optional owner lock input is compiled in with ARBITER8WAY16_LOCK_EN.

module mux8way16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
   input  logic [2:0]  sel,
   output logic [15:0] out
);

   always_comb begin
      out = a;
      case (sel)
         3'd0: out = a;
         3'd1: out = b;
         3'd2: out = c;
         3'd3: out = d;
         3'd4: out = e;
         3'd5: out = f;
         3'd6: out = g;
         3'd7: out = h;
         default: out = a;
      endcase
   end

endmodule

module arbiter8way16 #(
   parameter int HOLD_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  req,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
`ifdef ARBITER8WAY16_LOCK_EN
   input  logic        lock,
`endif
   output logic [7:0]  gnt,
   output logic [2:0]  sel,
   output logic        valid,
   output logic [15:0] out
);

   // Handshake: req[i] is a level held by requester i; it owns the bus for every
   // cycle in which valid=1 and gnt[i]=1, and releases it by dropping req[i].

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] HOLD = 4'(HOLD_MAX);

   state_t      state_q, state_d;
   logic [2:0]  sel_q, sel_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [7:0]  owner_mask;
   logic        owner_req;
   logic        others;
   logic        hold_lock;
   logic [2:0]  scan_base;
   logic [2:0]  winner;
   logic [15:0] mux_out;

   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
      logic [2:0] idx;
      logic [2:0] pick;
      logic       found;
      pick  = base;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = base + 3'(k);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

`ifdef ARBITER8WAY16_LOCK_EN
   assign hold_lock = lock;
`else
   assign hold_lock = 1'b0;
`endif

   assign owner_mask = 8'd1 << sel_q;
   assign owner_req  = |(req & owner_mask);
   assign others     = |(req & ~owner_mask);

   // In GRANT every rotation restarts the scan just past the current owner.
   assign scan_base  = (state_q == GRANT) ? (sel_q + 3'd1) : ptr_q;
   assign winner     = rr_pick(req, scan_base);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         ptr_q   <= 3'd0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               sel_d   = winner;
               cnt_d   = 4'd1;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               ptr_d = sel_q + 3'd1;
               if (others) begin
                  sel_d = winner;
                  cnt_d = 4'd1;
               end else begin
                  state_d = IDLE;
                  sel_d   = 3'd0;
                  cnt_d   = 4'd0;
               end
            end else if ((cnt_q >= HOLD) && others && !hold_lock) begin
               ptr_d = sel_q + 3'd1;
               sel_d = winner;
               cnt_d = 4'd1;
            end else begin
               cnt_d = (cnt_q >= HOLD) ? HOLD : (cnt_q + 4'd1);
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = 3'd0;
            cnt_d   = 4'd0;
         end
      endcase
   end

   mux8way16 u_mux (
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .e   (e),
      .f   (f),
      .g   (g),
      .h   (h),
      .sel (sel_q),
      .out (mux_out)
   );

   assign valid = (state_q == GRANT);
   assign sel   = sel_q;
   assign gnt   = valid ? owner_mask : 8'd0;
   assign out   = valid ? mux_out : 16'h0000;

endmodule

// File: tb/tb_arbiter8way16.sv
// Self-checking bench for arbiter8way16 against a round-robin reference model.
// Define ARBITER8WAY16_LOCK_EN to include the lock port and its scenario.

module tb_arbiter8way16;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  req = 8'h00;
   logic [15:0] dat [8];
   logic        lock_val = 1'b0;
   logic [7:0]  gnt;
   logic [2:0]  sel;
   logic        valid;
   logic [15:0] out;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state: owner = -1 when idle
   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;

   logic        exp_valid;
   logic [2:0]  exp_sel;
   logic [7:0]  exp_gnt;
   logic [15:0] exp_out;

   always #5 clk = ~clk;

   arbiter8way16 #(.HOLD_MAX(HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .a     (dat[0]),
      .b     (dat[1]),
      .c     (dat[2]),
      .d     (dat[3]),
      .e     (dat[4]),
      .f     (dat[5]),
      .g     (dat[6]),
      .h     (dat[7]),
`ifdef ARBITER8WAY16_LOCK_EN
      .lock  (lock_val),
`endif
      .gnt   (gnt),
      .sel   (sel),
      .valid (valid),
      .out   (out)
   );

   function automatic int rr_search(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++) begin
         if (r[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   function automatic bit lock_active();
`ifdef ARBITER8WAY16_LOCK_EN
      return lock_val;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_step();
      logic [7:0] rest;
      if (reset) begin
         m_owner = -1;
         m_ptr   = 0;
         m_cnt   = 0;
      end else if (m_owner < 0) begin
         if (req != 8'h00) begin
            m_owner = rr_search(req, m_ptr);
            m_cnt   = 1;
         end
      end else begin
         rest = req;
         rest[m_owner] = 1'b0;
         if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % 8;
            if (rest != 8'h00) begin
               m_owner = rr_search(req, m_ptr);
               m_cnt   = 1;
            end else begin
               m_owner = -1;
               m_cnt   = 0;
            end
         end else if (m_cnt == HOLD && rest != 8'h00 && !lock_active()) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = rr_search(rest, m_ptr);
            m_cnt   = 1;
         end else begin
            m_cnt = (m_cnt + 1 > HOLD) ? HOLD : m_cnt + 1;
         end
      end
   endtask

   // Advance one edge, update the model, and leave time 1 unit past the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      exp_valid = (m_owner >= 0);
      exp_sel   = exp_valid ? 3'(m_owner) : 3'd0;
      exp_gnt   = exp_valid ? (8'd1 << m_owner) : 8'd0;
      exp_out   = exp_valid ? dat[m_owner] : 16'h0000;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 8'h00;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = 8'hFF;
      for (int i = 0; i < 8; i++) dat[i] = 16'($urandom);
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (cyc == 2) begin
            reset = 1'b0;
            req   = 8'h00;
         end
         tick();
         n_checks++;
         if ({valid, gnt, out} !== {1'b0, 8'h00, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_idle cyc %0d: valid=%b gnt=%h out=%h, expected 0/00/0000", cyc, valid, gnt, out);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      dat[2] = 16'hAA00;
      req    = 8'h04;
      tick();
      n_checks++;
      if ({valid, gnt, sel, out} !== {1'b1, 8'h04, 3'd2, 16'hAA00}) begin
         n_fail++;
         $display("FAIL single_grant: valid=%b gnt=%h sel=%0d out=%h, expected 1/04/2/aa00", valid, gnt, sel, out);
      end
      req = 8'h00;
      tick();
      n_checks++;
      if ({valid, gnt, out} !== {1'b0, 8'h00, 16'h0000}) begin
         n_fail++;
         $display("FAIL single_release: valid=%b gnt=%h out=%h, expected 0/00/0000", valid, gnt, out);
      end
      // ptr is now 3, so requester 3 beats requester 0
      req = 8'h09;
      tick();
      n_checks++;
      if ({valid, sel} !== {1'b1, 3'd3}) begin
         n_fail++;
         $display("FAIL single_ptr: valid=%b sel=%0d, expected 1/3", valid, sel);
      end
      req = 8'h00;
      tick();
   endtask

   task automatic test_round_robin();
      int want [3] = '{0, 7, 0};
      logic [7:0] pat [3] = '{8'h81, 8'h80, 8'h01};
      do_reset();
      for (int i = 0; i < 8; i++) dat[i] = 16'($urandom);
      for (int s = 0; s < 3; s++) begin
         req = pat[s];
         tick();
         n_checks++;
         if ({valid, sel, out} !== {1'b1, 3'(want[s]), dat[want[s]]}) begin
            n_fail++;
            $display("FAIL round_robin step %0d: valid=%b sel=%0d out=%h, expected 1/%0d/%h", s, valid, sel, out, want[s], dat[want[s]]);
         end
      end
      req = 8'h00;
      tick();
   endtask

   task automatic test_hold_limit();
      int want [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
      do_reset();
      req = 8'h03;
      for (int cyc = 0; cyc < 12; cyc++) begin
         tick();
         n_checks++;
         if ({valid, sel, gnt} !== {1'b1, 3'(want[cyc]), 8'd1 << want[cyc]}) begin
            n_fail++;
            $display("FAIL hold_limit cyc %0d: valid=%b sel=%0d gnt=%h, expected 1/%0d", cyc, valid, sel, gnt, want[cyc]);
         end
      end
      req = 8'h00;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 8'h20;
      tick();
      req = 8'h21;
      tick();
      n_checks++;
      if ({valid, sel} !== {1'b1, 3'd5}) begin
         n_fail++;
         $display("FAIL mid_setup: valid=%b sel=%0d, expected 1/5", valid, sel);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if ({valid, gnt, sel, out} !== {1'b0, 8'h00, 3'd0, 16'h0000}) begin
         n_fail++;
         $display("FAIL mid_reset: valid=%b gnt=%h sel=%0d out=%h, expected 0/00/0/0000", valid, gnt, sel, out);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if ({valid, sel} !== {1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL mid_regrant: valid=%b sel=%0d, expected 1/0", valid, sel);
      end
      req = 8'h00;
      tick();
   endtask

`ifdef ARBITER8WAY16_LOCK_EN
   task automatic test_lock();
      do_reset();
      req      = 8'h03;
      lock_val = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick();
         n_checks++;
         if ({valid, sel} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL lock_hold cyc %0d: valid=%b sel=%0d, expected 1/0", cyc, valid, sel);
         end
      end
      lock_val = 1'b0;
      tick();
      n_checks++;
      if ({valid, sel} !== {1'b1, 3'd1}) begin
         n_fail++;
         $display("FAIL lock_release: valid=%b sel=%0d, expected 1/1", valid, sel);
      end
      req = 8'h00;
      tick();
   endtask
`endif

   task automatic test_random();
      int errs_here = 0;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         if ($urandom_range(0, 3) == 0) req = 8'($urandom);
         if ($urandom_range(0, 5) == 0) dat[$urandom_range(0, 7)] = 16'($urandom);
         reset = ($urandom_range(0, 60) == 0);
`ifdef ARBITER8WAY16_LOCK_EN
         if ($urandom_range(0, 7) == 0) lock_val = ~lock_val;
`endif
         tick();
         n_checks++;
         if ({valid, sel, gnt, out} !== {exp_valid, exp_sel, exp_gnt, exp_out}) begin
            n_fail++;
            errs_here++;
            if (errs_here <= 10)
               $display("FAIL random cyc %0d: valid/sel/gnt/out=%b/%0d/%h/%h, expected %b/%0d/%h/%h",
                        cyc, valid, sel, gnt, out, exp_valid, exp_sel, exp_gnt, exp_out);
         end
      end
      reset    = 1'b0;
      lock_val = 1'b0;
      req      = 8'h00;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 8; i++) dat[i] = 16'h0000;
      test_reset();
      test_single();
      test_round_robin();
      test_hold_limit();
      test_reset_mid_grant();
`ifdef ARBITER8WAY16_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
